// File: rtl/pwm_scheduler_if.sv
// Connects the SPI configuration registers to the PWM scheduler and carries
// the registered pin drive and period marker back out.
interface pwm_scheduler_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );
endinterface

// File: rtl/pwm_scheduler.sv
// Drives 16 output pins as constant-on or shared-duty PWM.  Live configuration
// is copied into shadow registers only at period boundaries, so pins never glitch.
module pwm_scheduler #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_scheduler_if.slave bus
);

    localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       pwm_cnt;

    logic [15:0]      sh_en_out;
    logic [15:0]      sh_en_pwm;
    logic [7:0]       sh_duty;

    logic [15:0]      out_q;
    logic             period_start_q;

    logic             tick;
    logic             wrap;
    logic             load;
    logic             lvl;
    logic [15:0]      live_en_out;
    logic [15:0]      live_en_pwm;
    logic [15:0]      out_d;

    assign live_en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign live_en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // Counting is held off during the post-reset load cycle so the first
    // period starts cleanly at pwm_cnt=0, div_cnt=0.
    assign tick = (state == ST_RUN) && (div_cnt == DIV_LAST);
    assign wrap = tick && (pwm_cnt == 8'hFF);
    assign load = (state == ST_LOAD) || wrap;

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_LOAD;
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            state <= ST_RUN;
            if (state == ST_RUN) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    pwm_cnt <= pwm_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en_out <= '0;
            sh_en_pwm <= '0;
            sh_duty   <= '0;
        end else if (load) begin
            sh_en_out <= live_en_out;
            sh_en_pwm <= live_en_pwm;
            sh_duty   <= bus.pwm_duty_cycle;
        end
    end

    // NOTE: defaults are assigned first in always_comb so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        lvl   = 1'b0;
        out_d = '0;
        if (sh_duty == 8'hFF) begin
            lvl = 1'b1;
        end else begin
            lvl = (pwm_cnt < sh_duty);
        end
        out_d = sh_en_out & (~sh_en_pwm | {16{lvl}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            out_q          <= out_d;
            period_start_q <= load;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;

endmodule
